acq_trig_sequencer: RTL and testbench

Acquisition trigger controller that sits between the trigger sources and the ADC/DAC capture datapath. It arms on software command and selects one of several trigger inputs. It applies a programmable clock-cycle delay after the trigger edge, then waits for the next valid sample before issuing the trigger. It then gates a fixed number of valid samples into the capture buffer, optionally re-arming automatically.

---
 rtl/acq_trig_sequencer_if.sv | 46 ++++
 rtl/acq_trig_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_acq_trig_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/acq_trig_sequencer_if.sv
// ----------------------------------------------------------------------------
// acq_trig_sequencer_if
// Bundles the control, trigger and status signals of the acquisition trigger
// sequencer. The clock and reset are kept outside as plain module ports.
//
// Signals
//   arm, abort, auto_rearm : sequence control (master -> slave)
//   trig_src, src_sel      : raw trigger sources and selected index
//   delay, length          : programmed trigger delay / capture length
//   valid                  : data-valid strobe from the datapath
//   trig_out, capture_en   : trigger pulse and capture-buffer write enable
//   busy, done, state      : sequencer status
//   trig_count             : number of trigger pulses issued since reset
// ----------------------------------------------------------------------------
interface acq_trig_sequencer_if #(
    parameter int CNT_WIDTH = 32,
    parameter int N_SRC     = 4,
    parameter int SEL_WIDTH = 2
);
    logic                  arm;
    logic                  abort;
    logic                  auto_rearm;
    logic [N_SRC-1:0]      trig_src;
    logic [SEL_WIDTH-1:0]  src_sel;
    logic [CNT_WIDTH-1:0]  delay;
    logic [CNT_WIDTH-1:0]  length;
    logic                  valid;
    logic                  trig_out;
    logic                  capture_en;
    logic                  busy;
    logic                  done;
    logic [2:0]            state;
    logic [CNT_WIDTH-1:0]  trig_count;

    // Controller / trigger-source side
    modport master (
        output arm, abort, auto_rearm, trig_src, src_sel, delay, length, valid,
        input  trig_out, capture_en, busy, done, state, trig_count
    );

    // Sequencer side
    modport slave (
        input  arm, abort, auto_rearm, trig_src, src_sel, delay, length, valid,
        output trig_out, capture_en, busy, done, state, trig_count
    );
endinterface

// File: rtl/acq_trig_sequencer.sv
// ----------------------------------------------------------------------------
// acq_trig_sequencer
// Acquisition trigger controller. Arms on command, detects a rising edge on
// the selected trigger source, waits a programmable number of clocks, then
// waits for the next valid sample, issues a one-cycle trigger and gates a
// fixed number of valid samples into the capture buffer. Can re-arm itself.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : acq_trig_sequencer_if.slave (control inputs, status outputs)
// ----------------------------------------------------------------------------
module acq_trig_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int N_SRC     = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    acq_trig_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARMED      = 3'd1,
        S_DELAY      = 3'd2,
        S_WAIT_VALID = 3'd3,
        S_CAPTURE    = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_dcnt;
    logic [CNT_WIDTH-1:0]   w_dcnt_nxt;
    logic [CNT_WIDTH-1:0]   r_scnt;
    logic [CNT_WIDTH-1:0]   w_scnt_nxt;
    logic [CNT_WIDTH-1:0]   r_trig_count;
    logic [CNT_WIDTH-1:0]   w_trig_count_nxt;
    logic                   r_prev;
    logic                   r_trig_out;
    logic                   w_trig_out_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic [N_SRC-1:0]       w_sel_mask;
    logic                   w_sel;
    logic                   w_edge;

    // One-hot decode of the source index; an index with no matching source
    // yields an all-zero mask, so out-of-range selections never trigger.
    always_comb begin
        w_sel_mask = {N_SRC{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            w_sel_mask[i] = (bus.src_sel == SEL_WIDTH'(i));
        end
    end

    assign w_sel  = |(bus.trig_src & w_sel_mask);
    assign w_edge = w_sel & ~r_prev;

    // Previous selected-source level, tracked in every state so that a source
    // already high when arming needs a fresh rising edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sel;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_dcnt       <= CNT_ZERO;
            r_scnt       <= CNT_ZERO;
            r_trig_count <= CNT_ZERO;
            r_trig_out   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_scnt       <= w_scnt_nxt;
            r_trig_count <= w_trig_count_nxt;
            r_trig_out   <= w_trig_out_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // Next-state and next-output logic. Abort overrides every transition and
    // leaves done and the counters untouched.
    always_comb begin
        w_state_nxt      = r_state;
        w_dcnt_nxt       = r_dcnt;
        w_scnt_nxt       = r_scnt;
        w_trig_count_nxt = r_trig_count;
        w_trig_out_nxt   = 1'b0;
        w_done_nxt       = r_done;

        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.arm) begin
                        w_state_nxt = S_ARMED;
                        w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end

                S_ARMED: begin
                    if (w_edge) begin
                        w_dcnt_nxt  = bus.delay;
                        w_state_nxt = (bus.delay != CNT_ZERO) ? S_DELAY : S_WAIT_VALID;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end

                // Free-running countdown; <= guards against a zero count.
                S_DELAY: begin
                    w_dcnt_nxt = r_dcnt - CNT_ONE;
                    if (r_dcnt <= CNT_ONE) begin
                        w_state_nxt = S_WAIT_VALID;
                    end else begin
                        w_state_nxt = S_DELAY;
                    end
                end

                // The aligning sample itself is not captured.
                S_WAIT_VALID: begin
                    if (bus.valid) begin
                        w_trig_out_nxt   = 1'b1;
                        w_trig_count_nxt = r_trig_count + CNT_ONE;
                        w_scnt_nxt       = bus.length;
                        if (bus.length == CNT_ZERO) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = bus.auto_rearm ? S_ARMED : S_IDLE;
                        end else begin
                            w_state_nxt = S_CAPTURE;
                        end
                    end else begin
                        w_state_nxt = S_WAIT_VALID;
                    end
                end

                S_CAPTURE: begin
                    if (bus.valid) begin
                        w_scnt_nxt = r_scnt - CNT_ONE;
                        if (r_scnt <= CNT_ONE) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = bus.auto_rearm ? S_ARMED : S_IDLE;
                        end else begin
                            w_state_nxt = S_CAPTURE;
                        end
                    end else begin
                        w_state_nxt = S_CAPTURE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // capture_en follows valid combinationally so it drops as soon as the
    // state leaves CAPTURE, including on an asynchronous reset.
    assign bus.capture_en = (r_state == S_CAPTURE) & bus.valid;
    assign bus.trig_out   = r_trig_out;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.state      = r_state;
    assign bus.trig_count = r_trig_count;

endmodule

// File: tb/tb_acq_trig_sequencer.sv
module tb_acq_trig_sequencer;

    localparam int CW = 32;
    localparam int NS = 4;
    localparam int SW = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    acq_trig_sequencer_if #(.CNT_WIDTH(CW), .N_SRC(NS), .SEL_WIDTH(SW)) dif();

    acq_trig_sequencer #(.CNT_WIDTH(CW), .N_SRC(NS), .SEL_WIDTH(SW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            reps;
        logic          arm;
        logic          abort;
        logic          ar;
        logic [NS-1:0] src;
        logic [SW-1:0] sel;
        logic [CW-1:0] dly;
        logic [CW-1:0] len;
        logic          vld;
        logic [2:0]    st;
        logic          tout;
        logic          cen;
        logic          dn;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int reps, int arm, int abort, int ar, int src, int sel,
                                int dly, int len, int vld, int st, int tout, int cen,
                                int dn, int cnt);
        vec_t v;
        v.reps  = reps;
        v.arm   = (arm != 0);
        v.abort = (abort != 0);
        v.ar    = (ar != 0);
        v.src   = src[NS-1:0];
        v.sel   = sel[SW-1:0];
        v.dly   = dly;
        v.len   = len;
        v.vld   = (vld != 0);
        v.st    = st[2:0];
        v.tout  = (tout != 0);
        v.cen   = (cen != 0);
        v.dn    = (dn != 0);
        v.cnt   = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        dif.arm        = v.arm;
        dif.abort      = v.abort;
        dif.auto_rearm = v.ar;
        dif.trig_src   = v.src;
        dif.src_sel    = v.sel;
        dif.delay      = v.dly;
        dif.length     = v.len;
        dif.valid      = v.vld;
    endtask

    task automatic check_outputs(string tag, logic [2:0] st, logic tout, logic cen,
                                 logic dn, logic [CW-1:0] cnt);
        chk({tag, ".state"},      32'(dif.state),      32'(st));
        chk({tag, ".trig_out"},   32'(dif.trig_out),   32'(tout));
        chk({tag, ".capture_en"}, 32'(dif.capture_en), 32'(cen));
        chk({tag, ".done"},       32'(dif.done),       32'(dn));
        chk({tag, ".busy"},       32'(dif.busy),       32'(st != 3'd0));
        chk({tag, ".trig_count"}, dif.trig_count,      cnt);
    endtask

    // Entered just after a rising edge: drive, check mid-cycle, advance.
    task automatic step(vec_t v, string tag);
        for (int r = 0; r < v.reps; r++) begin
            drive(v);
            @(negedge clk);
            check_outputs($sformatf("%s.%0d", tag, r), v.st, v.tout, v.cen, v.dn, v.cnt);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Fields: reps arm abort ar src sel dly len vld | st tout cen dn cnt
        // Basic capture: delay 5, length 8, sustained valid; edge at row 2.
        vecs.push_back(mk(1, 1,0,0, 0,2, 5,8,1,   0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,2, 5,8,1,   1,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 4,2, 5,8,1,   1,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 4,2, 9,8,1,   2,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,2, 9,8,1,   2,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 4,2, 9,8,1,   2,0,0,0,0));
        vecs.push_back(mk(2, 0,0,0, 4,2, 9,8,1,   2,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 4,2, 9,8,1,   3,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 4,2, 9,2,1,   4,1,1,0,1));
        vecs.push_back(mk(7, 0,0,0, 4,2, 9,2,1,   4,0,1,0,1));
        vecs.push_back(mk(1, 0,0,0, 0,2, 9,2,1,   0,0,0,1,1));
        // Sparse valid: delay 0, length 3, valid every 4th cycle.
        vecs.push_back(mk(1, 1,0,0, 0,2, 0,3,0,   0,0,0,1,1));
        vecs.push_back(mk(1, 0,0,0, 0,2, 0,3,0,   1,0,0,0,1));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,0,   1,0,0,0,1));
        vecs.push_back(mk(2, 0,0,0, 4,2, 0,3,0,   3,0,0,0,1));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,1,   3,0,0,0,1));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,0,   4,1,0,0,2));
        vecs.push_back(mk(2, 0,0,0, 4,2, 0,3,0,   4,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,1,   4,0,1,0,2));
        vecs.push_back(mk(3, 0,0,0, 4,2, 0,3,0,   4,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,1,   4,0,1,0,2));
        vecs.push_back(mk(3, 0,0,0, 4,2, 0,3,0,   4,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,1,   4,0,1,0,2));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,3,0,   0,0,0,1,2));
        // Edge rules: held-high source, unselected edges, out-of-range select.
        vecs.push_back(mk(1, 1,0,0, 4,2, 0,3,0,   0,0,0,1,2));
        vecs.push_back(mk(4, 0,0,0, 4,2, 0,3,0,   1,0,0,0,2));
        vecs.push_back(mk(2, 0,0,0, 11,2, 0,3,0,  1,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 0,5, 0,3,0,   1,0,0,0,2));
        vecs.push_back(mk(2, 0,0,0, 15,5, 0,3,0,  1,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 0,5, 0,3,0,   1,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 0,2, 0,3,0,   1,0,0,0,2));
        vecs.push_back(mk(1, 0,1,0, 0,2, 0,3,0,   1,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 0,2, 0,3,0,   0,0,0,0,2));
        // Abort during a long capture, then arm+abort together in IDLE.
        vecs.push_back(mk(1, 1,0,0, 0,2, 0,100,1, 0,0,0,0,2));
        vecs.push_back(mk(1, 1,0,0, 4,2, 0,100,1, 1,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,100,1, 3,0,0,0,2));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,100,1, 4,1,1,0,3));
        vecs.push_back(mk(2, 0,0,0, 4,2, 0,100,1, 4,0,1,0,3));
        vecs.push_back(mk(1, 0,1,0, 4,2, 0,100,1, 4,0,1,0,3));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,100,1, 0,0,0,0,3));
        vecs.push_back(mk(1, 1,1,0, 4,2, 0,100,1, 0,0,0,0,3));
        vecs.push_back(mk(1, 0,0,0, 4,2, 0,100,1, 0,0,0,0,3));
        // Auto re-arm with length 0: three edges, three triggers, no capture.
        vecs.push_back(mk(1, 1,0,1, 0,2, 0,0,1,   0,0,0,0,3));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   1,0,0,0,3));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   3,0,0,0,3));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   1,1,0,1,4));
        vecs.push_back(mk(1, 0,0,1, 0,2, 0,0,1,   1,0,0,1,4));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   1,0,0,1,4));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   3,0,0,1,4));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   1,1,0,1,5));
        vecs.push_back(mk(1, 0,0,1, 0,2, 0,0,1,   1,0,0,1,5));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   1,0,0,1,5));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   3,0,0,1,5));
        vecs.push_back(mk(1, 0,0,1, 4,2, 0,0,1,   1,1,0,1,6));
        vecs.push_back(mk(1, 0,1,1, 0,2, 0,0,1,   1,0,0,1,6));
        vecs.push_back(mk(1, 0,0,0, 0,2, 0,0,1,   0,0,0,1,6));

        // Reset held for 5 cycles with arbitrary inputs.
        drive(mk(1, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0));
        resetn = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            dif.arm        = 1'($urandom);
            dif.abort      = 1'($urandom);
            dif.auto_rearm = 1'($urandom);
            dif.trig_src   = NS'($urandom);
            dif.src_sel    = SW'($urandom);
            dif.delay      = $urandom;
            dif.length     = $urandom;
            dif.valid      = 1'($urandom);
        end
        @(negedge clk);
        check_outputs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        drive(mk(1, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0));
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset in the middle of a capture.
        step(mk(1, 1,0,0, 0,2, 0,50,1, 0,0,0,1,6), "ar0");
        step(mk(1, 0,0,0, 4,2, 0,50,1, 1,0,0,0,6), "ar1");
        step(mk(1, 0,0,0, 4,2, 0,50,1, 3,0,0,0,6), "ar2");
        step(mk(1, 0,0,0, 4,2, 0,50,1, 4,1,1,0,7), "ar3");
        drive(mk(1, 0,0,0, 4,2, 0,50,1, 0,0,0,0,0));
        #1;
        chk("midcap.capture_en", 32'(dif.capture_en), 32'd1);
        resetn = 1'b0;
        #1;
        check_outputs("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        drive(mk(1, 0,0,0, 0,2, 0,3,0, 0,0,0,0,0));
        resetn = 1'b1;
        step(mk(1, 1,0,0, 0,2, 0,3,0, 0,0,0,0,0), "rec0");
        step(mk(1, 0,0,0, 0,2, 0,3,0, 1,0,0,0,0), "rec1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
